// File: rtl/dpi_prot_secret_multi.sv
// dpi_prot_secret_multi
// Multi-channel accumulator with optional saturation and a sticky overflow
// flag, plus a per-channel PIPE_DEPTH-stage data delay line with a valid bit.
// Channels are independent slices of the packed input/output buses.
module dpi_prot_secret_multi #(
    parameter int NUM_CH     = 2,
    parameter int ACC_W      = 32,
    parameter int DATA_W     = 129,
    parameter int PIPE_DEPTH = 1,
    parameter int SAT_EN     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        clear,
    input  logic [NUM_CH*ACC_W-1:0]  accum_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH*ACC_W-1:0]  accum_out,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH-1:0]        overflow
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ACC_W-1:0]  acc;
        logic              ovf;
        logic [ACC_W:0]    sum;
        logic [ACC_W-1:0]  add_val;
        logic [ACC_W-1:0]  addend;
        logic [DATA_W-1:0] stage_data [PIPE_DEPTH];
        logic [PIPE_DEPTH-1:0] stage_valid;

        assign addend = accum_in[c*ACC_W +: ACC_W];

        // Widened add so the carry out of the accumulator is visible, then
        // pick wrap or saturate for the stored value.
        always_comb begin
            sum     = {1'b0, acc} + {1'b0, addend};
            add_val = sum[ACC_W-1:0];
            if (SAT_EN != 0 && sum[ACC_W]) begin
                add_val = '1;
            end
        end

        // Accumulator and sticky overflow, priority rst > clear > in_valid > hold.
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (clear[c]) begin
                acc <= in_valid[c] ? addend : '0;
                ovf <= 1'b0;
            end else if (in_valid[c]) begin
                acc <= add_val;
                if (sum[ACC_W]) begin
                    ovf <= 1'b1;
                end
            end
        end

        // Delay line: data is captured every cycle, the valid bit qualifies it.
        // NOTE: the stage array is reset as well as the valid bits so that a
        // reset flushes in-flight beats and data_out reads zero afterwards.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < PIPE_DEPTH; k++) begin
                    stage_data[k]  <= '0;
                    stage_valid[k] <= 1'b0;
                end
            end else begin
                stage_data[0]  <= data_in[c*DATA_W +: DATA_W];
                stage_valid[0] <= in_valid[c];
                for (int k = 1; k < PIPE_DEPTH; k++) begin
                    stage_data[k]  <= stage_data[k-1];
                    stage_valid[k] <= stage_valid[k-1];
                end
            end
        end

        assign accum_out[c*ACC_W +: ACC_W]   = acc;
        assign overflow[c]                   = ovf;
        assign data_out[c*DATA_W +: DATA_W]  = stage_data[PIPE_DEPTH-1];
        assign out_valid[c]                  = stage_valid[PIPE_DEPTH-1];
    end

endmodule

// File: tb/tb_dpi_prot_secret_multi.sv
// tb_dpi_prot_secret_multi
// Three differently parameterised instances driven side by side; every cycle
// all outputs are compared against a cycle-indexed behavioural model, and the
// directed scenarios additionally check literal expected values.
module tb_dpi_prot_secret_multi;

    localparam int ND = 3;
    localparam int LOG_N = 1024;
    localparam int ACCW [ND] = '{32, 8, 33};
    localparam int DW   [ND] = '{129, 8, 70};
    localparam int DEP  [ND] = '{3, 1, 2};
    localparam int SAT  [ND] = '{0, 0, 1};

    logic clk = 1'b0;
    logic rst;
    logic [1:0]   iv  [ND];
    logic [1:0]   clr [ND];
    logic [255:0] ain [ND][2];
    logic [255:0] din [ND][2];

    logic [63:0]  a0_ai, a0_ao;
    logic [257:0] a0_di, a0_do;
    logic [1:0]   a0_ov, a0_of;
    logic [15:0]  a1_ai, a1_ao;
    logic [15:0]  a1_di, a1_do;
    logic [1:0]   a1_ov, a1_of;
    logic [65:0]  a2_ai, a2_ao;
    logic [139:0] a2_di, a2_do;
    logic [1:0]   a2_ov, a2_of;

    wire [255:0] o_acc  [ND][2];
    wire [255:0] o_data [ND][2];
    wire         o_val  [ND][2];
    wire         o_ovf  [ND][2];

    int checks = 0;
    int errors = 0;
    int n = 0;
    int last_rst = -1000;

    logic [255:0] m_acc [ND][2];
    logic         m_ovf [ND][2];
    logic [255:0] log_d [ND][2][LOG_N];
    logic         log_v [ND][2][LOG_N];

    always #5 clk = ~clk;

    assign a0_ai = {ain[0][1][31:0], ain[0][0][31:0]};
    assign a0_di = {din[0][1][128:0], din[0][0][128:0]};
    assign a1_ai = {ain[1][1][7:0], ain[1][0][7:0]};
    assign a1_di = {din[1][1][7:0], din[1][0][7:0]};
    assign a2_ai = {ain[2][1][32:0], ain[2][0][32:0]};
    assign a2_di = {din[2][1][69:0], din[2][0][69:0]};

    assign o_acc[0][0]  = 256'(a0_ao[31:0]);
    assign o_acc[0][1]  = 256'(a0_ao[63:32]);
    assign o_acc[1][0]  = 256'(a1_ao[7:0]);
    assign o_acc[1][1]  = 256'(a1_ao[15:8]);
    assign o_acc[2][0]  = 256'(a2_ao[32:0]);
    assign o_acc[2][1]  = 256'(a2_ao[65:33]);
    assign o_data[0][0] = 256'(a0_do[128:0]);
    assign o_data[0][1] = 256'(a0_do[257:129]);
    assign o_data[1][0] = 256'(a1_do[7:0]);
    assign o_data[1][1] = 256'(a1_do[15:8]);
    assign o_data[2][0] = 256'(a2_do[69:0]);
    assign o_data[2][1] = 256'(a2_do[139:70]);
    assign o_val[0][0] = a0_ov[0];
    assign o_val[0][1] = a0_ov[1];
    assign o_val[1][0] = a1_ov[0];
    assign o_val[1][1] = a1_ov[1];
    assign o_val[2][0] = a2_ov[0];
    assign o_val[2][1] = a2_ov[1];
    assign o_ovf[0][0] = a0_of[0];
    assign o_ovf[0][1] = a0_of[1];
    assign o_ovf[1][0] = a1_of[0];
    assign o_ovf[1][1] = a1_of[1];
    assign o_ovf[2][0] = a2_of[0];
    assign o_ovf[2][1] = a2_of[1];

    dpi_prot_secret_multi #(.NUM_CH(2), .ACC_W(32), .DATA_W(129), .PIPE_DEPTH(3), .SAT_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .clear(clr[0]), .accum_in(a0_ai), .data_in(a0_di),
        .accum_out(a0_ao), .data_out(a0_do), .out_valid(a0_ov), .overflow(a0_of));

    dpi_prot_secret_multi #(.NUM_CH(2), .ACC_W(8), .DATA_W(8), .PIPE_DEPTH(1), .SAT_EN(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .clear(clr[1]), .accum_in(a1_ai), .data_in(a1_di),
        .accum_out(a1_ao), .data_out(a1_do), .out_valid(a1_ov), .overflow(a1_of));

    dpi_prot_secret_multi #(.NUM_CH(2), .ACC_W(33), .DATA_W(70), .PIPE_DEPTH(2), .SAT_EN(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .clear(clr[2]), .accum_in(a2_ai), .data_in(a2_di),
        .accum_out(a2_ao), .data_out(a2_do), .out_valid(a2_ov), .overflow(a2_of));

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All channels idle with random (unqualified) data on every bus.
    task automatic quiet();
        for (int d = 0; d < ND; d++) begin
            iv[d]  = 2'b00;
            clr[d] = 2'b00;
            for (int c = 0; c < 2; c++) begin
                ain[d][c] = rand256();
                din[d][c] = rand256();
            end
        end
    endtask

    // Random controls; addends are sometimes small so sums can build up.
    task automatic rand_inputs();
        for (int d = 0; d < ND; d++) begin
            iv[d] = 2'($urandom);
            for (int c = 0; c < 2; c++) begin
                clr[d][c] = ($urandom_range(0, 7) == 0);
                ain[d][c] = ($urandom_range(0, 1) == 0) ? rand256() : 256'($urandom_range(0, 40));
                din[d][c] = rand256();
            end
        end
    endtask

    // One clock: update the model from the inputs sampled at the edge, then
    // compare every output of every instance shortly after the edge.
    task automatic tick();
        logic [255:0] mask, dmask, sum, exp_d;
        logic exp_v;
        int k;
        @(posedge clk);
        if (n >= LOG_N) begin
            $display("FAIL log_bound: observed cycle %0d required below %0d", n, LOG_N);
            $fatal(1, "cycle log exhausted");
        end
        for (int d = 0; d < ND; d++) begin
            mask  = (256'd1 << ACCW[d]) - 256'd1;
            dmask = (256'd1 << DW[d]) - 256'd1;
            for (int c = 0; c < 2; c++) begin
                if (rst) begin
                    m_acc[d][c] = '0;
                    m_ovf[d][c] = 1'b0;
                end else if (clr[d][c]) begin
                    m_acc[d][c] = iv[d][c] ? (ain[d][c] & mask) : '0;
                    m_ovf[d][c] = 1'b0;
                end else if (iv[d][c]) begin
                    sum = m_acc[d][c] + (ain[d][c] & mask);
                    if (sum > mask) begin
                        m_ovf[d][c] = 1'b1;
                        m_acc[d][c] = (SAT[d] != 0) ? mask : (sum & mask);
                    end else begin
                        m_acc[d][c] = sum;
                    end
                end
                log_d[d][c][n] = rst ? '0 : (din[d][c] & dmask);
                log_v[d][c][n] = rst ? 1'b0 : iv[d][c];
            end
        end
        if (rst) last_rst = n;
        #1;
        for (int d = 0; d < ND; d++) begin
            k = n - DEP[d] + 1;
            for (int c = 0; c < 2; c++) begin
                if (k < 0 || last_rst >= k) begin
                    exp_d = '0;
                    exp_v = 1'b0;
                end else begin
                    exp_d = log_d[d][c][k];
                    exp_v = log_v[d][c][k];
                end
                check($sformatf("acc d%0d c%0d n%0d", d, c, n), o_acc[d][c], m_acc[d][c]);
                check($sformatf("ovf d%0d c%0d n%0d", d, c, n), 256'(o_ovf[d][c]), 256'(m_ovf[d][c]));
                check($sformatf("data d%0d c%0d n%0d", d, c, n), o_data[d][c], exp_d);
                check($sformatf("valid d%0d c%0d n%0d", d, c, n), 256'(o_val[d][c]), 256'(exp_v));
            end
        end
        n++;
    endtask

    initial begin
        logic [255:0] pat, beat;

        // Reset for two cycles with random inputs.
        rst = 1'b1;
        rand_inputs();
        tick();
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < 2; c++) begin
                check("rst1_acc", o_acc[d][c], '0);
                check("rst1_valid", 256'(o_val[d][c]), '0);
            end
        rand_inputs();
        tick();
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < 2; c++) begin
                check("rst2_data", o_data[d][c], '0);
                check("rst2_ovf", 256'(o_ovf[d][c]), '0);
            end
        rst = 1'b0;

        // Accumulate on the 32-bit instance: load 0 / 100, then ten +5 beats.
        quiet();
        clr[0] = 2'b11;
        iv[0]  = 2'b11;
        ain[0][0] = 256'd0;
        ain[0][1] = 256'd100;
        tick();
        check("load_ch0", o_acc[0][0], 256'd0);
        check("load_ch1", o_acc[0][1], 256'd100);
        clr[0] = 2'b00;
        ain[0][0] = 256'd5;
        ain[0][1] = 256'd5;
        repeat (10) tick();
        check("accum_ch0", o_acc[0][0], 256'd50);
        check("accum_ch1", o_acc[0][1], 256'd150);
        check("accum_ovf0", 256'(o_ovf[0][0]), '0);
        check("accum_ovf1", 256'(o_ovf[0][1]), '0);

        // Wrap on the 8-bit instance: 250 + 10 -> 4 with sticky overflow.
        quiet();
        clr[1] = 2'b01;
        iv[1]  = 2'b01;
        ain[1][0] = 256'd250;
        tick();
        clr[1] = 2'b00;
        ain[1][0] = 256'd10;
        tick();
        check("wrap_acc", o_acc[1][0], 256'd4);
        check("wrap_ovf", 256'(o_ovf[1][0]), 256'd1);
        quiet();
        repeat (3) tick();
        check("wrap_ovf_sticky", 256'(o_ovf[1][0]), 256'd1);
        check("wrap_acc_hold", o_acc[1][0], 256'd4);
        clr[1] = 2'b01;
        tick();
        check("wrap_clear_acc", o_acc[1][0], '0);
        check("wrap_clear_ovf", 256'(o_ovf[1][0]), '0);

        // Saturate on the 33-bit instance: (2^33-3) + 5 -> 2^33-1.
        quiet();
        clr[2] = 2'b10;
        iv[2]  = 2'b10;
        ain[2][1] = (256'd1 << 33) - 256'd3;
        tick();
        clr[2] = 2'b00;
        ain[2][1] = 256'd5;
        tick();
        check("sat_acc", o_acc[2][1], (256'd1 << 33) - 256'd1);
        check("sat_ovf", 256'(o_ovf[2][1]), 256'd1);
        quiet();
        clr[2] = 2'b10;
        tick();
        check("sat_clear_acc", o_acc[2][1], '0);
        check("sat_clear_ovf", 256'(o_ovf[2][1]), '0);

        // Walking one through the 129-bit, 3-deep delay line on channel 0.
        quiet();
        pat = rand256() & ((256'd1 << 129) - 256'd1);
        din[0][1] = pat;
        iv[0] = 2'b01;
        din[0][0] = 256'd1 << 128;
        tick();
        din[0][0] = 256'd1 << 64;
        tick();
        check("walk_pre_valid", 256'(o_val[0][0]), '0);
        din[0][0] = 256'd1;
        tick();
        iv[0] = 2'b00;
        din[0][0] = '0;
        check("walk_b128", o_data[0][0], 256'd1 << 128);
        check("walk_b128_v", 256'(o_val[0][0]), 256'd1);
        check("walk_other_slice", o_data[0][1], pat);
        tick();
        check("walk_b64", o_data[0][0], 256'd1 << 64);
        check("walk_b64_v", 256'(o_val[0][0]), 256'd1);
        tick();
        check("walk_b0", o_data[0][0], 256'd1);
        check("walk_other_valid", 256'(o_val[0][1]), '0);
        tick();
        check("walk_post_valid", 256'(o_val[0][0]), '0);

        // Reset one cycle after a beat: that beat never emerges.
        quiet();
        iv[0] = 2'b01;
        tick();
        iv[0] = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_valid", 256'(o_val[0][0]), '0);
        end
        beat = rand256() & ((256'd1 << 129) - 256'd1);
        iv[0] = 2'b01;
        din[0][0] = beat;
        tick();
        iv[0] = 2'b00;
        tick();
        check("post_rst_early", 256'(o_val[0][0]), '0);
        tick();
        check("post_rst_valid", 256'(o_val[0][0]), 256'd1);
        check("post_rst_data", o_data[0][0], beat);

        // Randomised traffic against the model, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 31) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
